// File: rtl/polylut_pkg.sv
// Shared widths, vector types and the layer0/layer1 combinational networks for polylut_stream.
// The layer functions have the generated networks' port widths and are swapped for the generated logic in the full flow.
package polylut_pkg;

  localparam int POLYLUT_IN_W   = 64;
  localparam int POLYLUT_MID_W  = 128;
  localparam int POLYLUT_OUT_W  = 20;
  localparam int POLYLUT_STAGES = 3;

  typedef logic [POLYLUT_IN_W-1:0]  in_vec_t;
  typedef logic [POLYLUT_MID_W-1:0] mid_vec_t;
  typedef logic [POLYLUT_OUT_W-1:0] out_vec_t;

  localparam logic [63:0] L0_KEY_HI = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] L0_KEY_LO = 64'h0123_4567_89AB_CDEF;

  function automatic mid_vec_t layer0(input in_vec_t x);
    return {({x[50:0], x[63:51]} ^ L0_KEY_HI), (x ^ L0_KEY_LO)};
  endfunction

  // Folds the 128-bit mid vector into 20 bits, 20-bit chunks from the LSB; top chunk is 8 bits.
  function automatic out_vec_t layer1(input mid_vec_t m);
    return m[19:0] ^ m[39:20] ^ m[59:40] ^ m[79:60] ^ m[99:80] ^ m[119:100]
           ^ {12'h000, m[127:120]};
  endfunction

endpackage

// File: rtl/polylut_pipe_stage.sv
// One valid/ready pipeline stage: valid bit plus an enabled W-bit data register.
// adv is this stage handing its sample downstream this cycle.
module polylut_pipe_stage
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         fill,
  input  logic [W-1:0] din,
  input  logic         down_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         adv
);

  assign adv = valid & down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= !flush & (fill | (valid & !adv));
      if (fill) data <= din;
    end
  end

endmodule

// File: rtl/polylut_stream.sv
// Three-stage back-pressurable PolyLUT inference pipeline (input, mid, output registers).
// Optional performance counters are built when POLYLUT_PERF_EN is defined.
module polylut_stream
  import polylut_pkg::*;
#(
  parameter int IN_W  = POLYLUT_IN_W,
  parameter int MID_W = POLYLUT_MID_W,
  parameter int OUT_W = POLYLUT_OUT_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       in_flight,
  output logic [CNT_W-1:0] perf_accepted,
  output logic [CNT_W-1:0] perf_stalls
);

  generate
    if (IN_W != POLYLUT_IN_W || MID_W != POLYLUT_MID_W || OUT_W != POLYLUT_OUT_W) begin : g_bad_width
      $error("polylut_stream: IN_W/MID_W/OUT_W must be 64/128/20 to match the generated layers");
    end
  endgenerate

  logic             v0, v1, v2;
  logic             adv0, adv1, adv2;
  logic             ready0, ready1, ready2;
  logic             fill0;
  logic [IN_W-1:0]  d0;
  logic [MID_W-1:0] d1, l0_out;
  logic [OUT_W-1:0] d2, l1_out;

  // Ready chain is purely combinational: a full pipe accepts whenever the output drains.
  assign ready2   = !v2 | adv2;
  assign ready1   = !v1 | adv1;
  assign ready0   = !v0 | adv0;
  assign in_ready = !flush & ready0;
  assign fill0    = in_valid & in_ready;

  assign l0_out = layer0(d0);
  assign l1_out = layer1(d1);

  polylut_pipe_stage #(.W(IN_W)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .fill(fill0), .din(in_data),
    .down_ready(ready1), .valid(v0), .data(d0), .adv(adv0)
  );

  polylut_pipe_stage #(.W(MID_W)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .fill(adv0), .din(l0_out),
    .down_ready(ready2), .valid(v1), .data(d1), .adv(adv1)
  );

  polylut_pipe_stage #(.W(OUT_W)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .fill(adv1), .din(l1_out),
    .down_ready(out_ready), .valid(v2), .data(d2), .adv(adv2)
  );

  assign out_valid = v2;
  assign out_data  = d2;
  assign in_flight = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};

`ifdef POLYLUT_PERF_EN
  logic [CNT_W-1:0] acc_q, stall_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (fill0) acc_q <= acc_q + CNT_W'(1);
      if (v2 & !out_ready) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign perf_accepted = acc_q;
  assign perf_stalls   = stall_q;
`else
  assign perf_accepted = '0;
  assign perf_stalls   = '0;
`endif

endmodule

// File: tb/tb_polylut_stream.sv
// Randomised testbench for polylut_stream against a queue-based behavioural model.
// Perf-counter checks follow POLYLUT_PERF_EN.
module tb_polylut_stream;

  localparam int CNT_W = 32;
  localparam logic [63:0] KEY_HI = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] KEY_LO = 64'h0123_4567_89AB_CDEF;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic [63:0]      in_data;
  logic             in_ready, out_valid;
  logic [19:0]      out_data;
  logic [1:0]       in_flight;
  logic [CNT_W-1:0] perf_accepted, perf_stalls;

  always #5 clk = ~clk;

  polylut_stream dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_flight(in_flight), .perf_accepted(perf_accepted), .perf_stalls(perf_stalls)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Golden layer1(layer0(x)) computed bit by bit.
  function automatic logic [19:0] golden(input logic [63:0] x);
    logic [127:0] m;
    logic [19:0]  r;
    for (int i = 0; i < 64; i++) begin
      m[i] = x[i] ^ KEY_LO[i];
      m[64 + ((i + 13) % 64)] = x[i] ^ KEY_HI[(i + 13) % 64];
    end
    r = '0;
    for (int b = 0; b < 128; b++) r[b % 20] = r[b % 20] ^ m[b];
    return r;
  endfunction

  // Model: queue of accepted-but-undelivered samples with their acceptance cycle.
  typedef struct {
    logic [63:0] d;
    int          acc;
  } ent_t;

  ent_t             q[$];
  int               cyc = 0;
  int               last_del = -100;
  logic [CNT_W-1:0] m_acc = '0;
  logic [CNT_W-1:0] m_stall = '0;
  int               dut_acc = 0;
  int               dut_del = 0;

  // Head is visible 3 cycles after acceptance, and no earlier than the cycle after the previous delivery.
  function automatic bit exp_present();
    int t;
    if (q.size() == 0) return 1'b0;
    t = q[0].acc + 3;
    if (last_del + 1 > t) t = last_del + 1;
    return cyc >= t;
  endfunction

  function automatic bit exp_ready();
    return !flush && !(q.size() == 3 && !out_ready);
  endfunction

  always @(posedge clk) begin
    bit pres, rdy;
    if (rst) begin
      q.delete();
      last_del = -100;
      m_acc    = '0;
      m_stall  = '0;
    end else begin
      pres = exp_present();
      rdy  = exp_ready();
      if (out_valid && out_ready) dut_del++;
      if (in_valid && in_ready) dut_acc++;
      if (pres && out_ready) begin
        void'(q.pop_front());
        last_del = cyc;
      end
      if (pres && !out_ready) m_stall++;
      if (in_valid && rdy) begin
        q.push_back('{d: in_data, acc: cyc});
        m_acc++;
      end
      if (flush) q.delete();
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_in_flight", 64'(in_flight), 64'd0);
      if (!flush) chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      chk("in_flight", 64'(in_flight), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("out_valid", 64'(out_valid), 64'(exp_present()));
      if (exp_present()) chk("out_data", 64'(out_data), 64'(golden(q[0].d)));
    end
`ifdef POLYLUT_PERF_EN
    chk("perf_accepted", 64'(perf_accepted), 64'(m_acc));
    chk("perf_stalls", 64'(perf_stalls), 64'(m_stall));
`else
    chk("perf_accepted_tied", 64'(perf_accepted), 64'd0);
    chk("perf_stalls_tied", 64'(perf_stalls), 64'd0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, n;
    logic [63:0] x;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    chk("golden_0", 64'(golden(64'h0)), 64'h3C33F);
    chk("golden_1", 64'(golden(64'h1)), 64'h1C33E);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // In-order stream at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();

    // Fill and stall, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = {$urandom(), $urandom()};
      tick();
    end
    chk("stall_in_flight", 64'(in_flight), 64'd3);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = {$urandom(), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();

    // Sparse input with toggling out_ready; every accepted sample must come out.
    a0 = dut_acc;
    d0 = dut_del;
    for (int i = 0; i < 40; i++) begin
      in_valid  = (i % 2) == 0;
      out_ready = (i % 2) == 1;
      in_data   = {$urandom(), $urandom()};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("sparse_accepted", 64'(dut_acc - a0), 64'd20);
    chk("sparse_delivered", 64'(dut_del - d0), 64'(dut_acc - a0));

    // Flush with a full pipe and a pending input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom(), $urandom()};
      tick();
    end
    chk("preflush_in_flight", 64'(in_flight), 64'd3);
    flush   = 1'b1;
    in_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("postflush_in_flight", 64'(in_flight), 64'd0);
    chk("postflush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (5) tick();

    // Asynchronous reset mid-stream, then first-sample latency.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom(), $urandom()};
      tick();
    end
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_flight", 64'(in_flight), 64'd0);
    tick();
    rst = 1'b0;
    x = 64'h0123_0000_ABCD_0042;
    in_data = x;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("post_rst_latency", 64'(n), 64'd3);
    chk("post_rst_data", 64'(out_data), 64'(golden(x)));
    repeat (3) tick();

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom() % 4) != 0;
      out_ready = ($urandom() % 3) != 0;
      flush     = ($urandom() % 25) == 0;
      in_data   = {$urandom(), $urandom()};
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    chk("drained_in_flight", 64'(in_flight), 64'd0);

`ifdef POLYLUT_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom(), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = {$urandom(), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("perf_acc_10", 64'(perf_accepted), 64'd10);
    chk("perf_stall_4", 64'(perf_stalls), 64'd4);

    force dut.acc_q = '1;
    release dut.acc_q;
    m_acc     = '1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h5;
    tick();
    in_valid = 1'b0;
    chk("perf_acc_wrap", 64'(perf_accepted), 64'd0);
    tick();
    tick();
    force dut.stall_q = '1;
    release dut.stall_q;
    m_stall = '1;
    tick();
    chk("perf_stall_wrap", 64'(perf_stalls), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polylut_stream.md
Name: polylut_stream

Overview:
- Streaming, back-pressurable successor to the two-layer PolyLUT inference top.
- Wraps the generated combinational layer0 (IN_W→MID_W) and layer1 (MID_W→OUT_W) LUT networks in a three-stage valid/ready pipeline: input, mid and output registers.
- Bubbles collapse, and a synchronous flush is provided.
- Sits between the feature-vector source and the classifier-result consumer, so upstream no longer needs a fixed every-cycle cadence.

Parameters:
- IN_W, 64, input address width; must equal layer0 input width.
- MID_W, 128, layer0 output / layer1 input width.
- OUT_W, 20, layer1 output width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous clear of all in-flight samples
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  IN_W  input feature address
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  OUT_W  layer1 result (M2)
- in_flight  output  2  number of valid stages, 0..3
- perf_accepted  output  CNT_W  accepted-input count (POLYLUT_PERF_EN only)
- perf_stalls  output  CNT_W  output stall-cycle count (POLYLUT_PERF_EN only)

Behaviour:
- Stages and data path:
  - s0 holds in_data; layer0 is driven from s0.
  - s1 holds layer0 output; layer1 is driven from s1.
  - s2 holds layer1 output and drives out_data.
  - out_valid = v2.
- Advance rules:
  - adv2 = v2 & out_ready.
  - adv1 = v1 & (!v2 | adv2).
  - adv0 = v0 & (!v1 | adv1).
  - in_ready = !flush & (!v0 | adv0). This is a combinational ready chain with no skid buffer.
- Stage updates:
  - Stage k data register loads only when stage k is filled: for s0, in_valid & in_ready; for s1 and s2, adv of the previous stage. Otherwise data holds.
  - vk next = filled_k | (vk & !adv_k).
- Latency and throughput:
  - A sample accepted in cycle c appears with out_valid=1 in cycle c+3 when there are no stalls.
  - Throughput is 1 sample/cycle with out_ready held high.
- Stalls:
  - If out_ready is low, out_data is held stable while out_valid=1.
  - Upstream stages fill remaining bubbles. in_ready falls only when all three stages are valid and out_ready=0.
- Ordering: samples leave in acceptance order; there is no drop and no duplication.
- in_flight = v0+v1+v2, registered-state derived and combinational from the valids.
- flush:
  - At the next edge, all vk clear; data registers are not cleared.
  - in_ready=0 during flush, so a simultaneous in_valid is not accepted.
  - out_valid may be high in the flush cycle. A handshake in that cycle still counts as delivered.
- Reset:
  - v0..v2, all data registers and perf counters go to 0 immediately on rst assertion, mid-operation included.
  - Port values in reset: out_valid=0, out_data=0, in_flight=0, in_ready=1 (provided flush=0).
- Elaboration: IN_W/MID_W/OUT_W not matching 64/128/20 is an elaboration error, reported via a generate-time $error.

Optional Feature:
- Macro POLYLUT_PERF_EN.
- Defined:
  - perf_accepted increments on each in_valid&in_ready.
  - perf_stalls increments on each cycle with out_valid & !out_ready.
  - Both wrap modulo 2^CNT_W, are cleared by rst, and are not cleared by flush.
- Undefined: the counters are absent, and both perf ports are tied to 0.

Decomposition:
- polylut_pkg:
  - Localparams POLYLUT_IN_W=64, POLYLUT_MID_W=128, POLYLUT_OUT_W=20, POLYLUT_STAGES=3.
  - Typedefs in_vec_t, mid_vec_t, out_vec_t.
- Sub-module polylut_pipe_stage #(W):
  - Contains the valid bit plus a W-bit enabled data register, with async reset and flush input.
  - Computes its own adv from its downstream ready.
  - Instantiated three times.

Test Plan:
1. Reset, then out_ready=1 and in_data=64'h0 followed by 64'h1..64'h9 on consecutive cycles → outputs appear from cycle 3 onward in order. Each out_data must equal the golden layer1(layer0(x)) model, with no gaps.
2. Fill the pipe and hold out_ready=0 for 5 cycles → in_flight reaches 3 and in_ready=0. out_data stays constant throughout. Releasing out_ready drains 3 samples, then new ones follow with no loss.
3. Drive in_valid every other cycle with out_ready toggling 1,0,1,0 → every accepted sample is delivered exactly once, in order. The scoreboard count of accepted inputs equals delivered outputs.
4. Assert flush for 1 cycle with in_flight=3 and in_valid=1 → the next cycle has in_flight=0 and out_valid=0. The flush-cycle input is not delivered.
5. Assert rst asynchronously mid-stream, between clock edges → out_valid and in_flight drop to 0 before the next edge. After release, the first accepted sample appears 3 cycles later.
6. With POLYLUT_PERF_EN: 10 accepted samples and 4 stall cycles → perf_accepted=10 and perf_stalls=4. Preload near 2^CNT_W−1 via force and confirm wrap to 0.
